chroma8x8_mode_decide: RTL

Downstream stage of the chroma 8x8 intra predictor. It latches the original 8x8 chroma block and the three candidate predictions (vertical, horizontal, DC). It then accumulates a SAD (sum of absolute differences) per mode, one row per cycle, and picks the lowest-cost mode. Finally it streams the signed residual of the winning mode, row by row, to the transform stage over a valid/ready handshake.

---
 rtl/chroma_pred_pkg.sv | 24 ++
 rtl/chroma8x8_mode_decide_sad_row8.sv | 22 ++
 rtl/chroma8x8_mode_decide.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/chroma_pred_pkg.sv
// Shared types and widths for the chroma 8x8 intra mode decision stage.
package chroma_pred_pkg;

    localparam int PIX_W     = 8;
    localparam int ROWS      = 8;
    localparam int SAD_W     = 14;
    localparam int RES_W     = 9;
    localparam int ROW_SAD_W = 11;

    // H.264 chroma intra mode numbering; value 3 is never produced
    typedef enum logic [1:0] {
        MODE_DC = 2'd0,
        MODE_H  = 2'd1,
        MODE_V  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DECIDE = 2'd2,
        ST_EMIT   = 2'd3
    } state_e;

endpackage

// File: rtl/chroma8x8_mode_decide_sad_row8.sv
// Combinational sum of absolute differences across one 8-pixel row.
module sad_row8
    import chroma_pred_pkg::*;
(
    input  logic [7:0][PIX_W-1:0] a_i,
    input  logic [7:0][PIX_W-1:0] b_i,
    output logic [ROW_SAD_W-1:0]  sum_o
);

    // Larger-minus-smaller keeps every term unsigned; 8 x 255 fits in 11 bits
    always_comb begin
        sum_o = '0;
        for (int c = 0; c < 8; c++) begin
            if (a_i[c] >= b_i[c]) begin
                sum_o = sum_o + ROW_SAD_W'(a_i[c] - b_i[c]);
            end else begin
                sum_o = sum_o + ROW_SAD_W'(b_i[c] - a_i[c]);
            end
        end
    end

endmodule

// File: rtl/chroma8x8_mode_decide.sv
// Chroma 8x8 mode decision: latches a block plus three predictions, accumulates
// one SAD per mode a row per cycle, picks the cheapest mode and streams its
// signed residual rows downstream over valid/ready.
module chroma8x8_mode_decide
    import chroma_pred_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    input  logic [63:0][PIX_W-1:0]    origpixels_i,
    input  logic [63:0][PIX_W-1:0]    vpred_i,
    input  logic [63:0][PIX_W-1:0]    hpred_i,
    input  logic [63:0][PIX_W-1:0]    dcpred_i,
    output logic                      busy_o,
    output logic                      mode_valid_o,
    output logic [1:0]                best_mode_o,
    output logic [SAD_W-1:0]          best_sad_o,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [2:0]                res_row_o,
    output logic                      res_last_o,
    output logic [7:0][RES_W-1:0]     res_data_o
);

    localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

    state_e                    state_q, state_d;
    logic [2:0]                row_q;
    logic [63:0][PIX_W-1:0]    origPix_q, vPred_q, hPred_q, dcPred_q;
    logic [SAD_W-1:0]          sadDc_q, sadH_q, sadV_q;
    mode_e                     bestMode_q;
    logic [SAD_W-1:0]          bestSad_q;
    logic                      modeValid_q;

    logic [7:0][PIX_W-1:0]     origRow, vRow, hRow, dcRow, bestRow;
    logic [ROW_SAD_W-1:0]      rowSadDc, rowSadH, rowSadV;
    mode_e                     winMode;
    logic [SAD_W-1:0]          winSad;

    // Pick out the current row of each latched array; the same row counter
    // serves both the accumulation pass and the residual pass
    always_comb begin
        origRow = '0;
        vRow    = '0;
        hRow    = '0;
        dcRow   = '0;
        for (int c = 0; c < 8; c++) begin
            origRow[c] = origPix_q[{row_q, 3'(c)}];
            vRow[c]    = vPred_q[{row_q, 3'(c)}];
            hRow[c]    = hPred_q[{row_q, 3'(c)}];
            dcRow[c]   = dcPred_q[{row_q, 3'(c)}];
        end
    end

    sad_row8 uSadDc (.a_i(origRow), .b_i(dcRow), .sum_o(rowSadDc));
    sad_row8 uSadH  (.a_i(origRow), .b_i(hRow),  .sum_o(rowSadH));
    sad_row8 uSadV  (.a_i(origRow), .b_i(vRow),  .sum_o(rowSadV));

    // Minimum search in mode order with strict less-than, so ties keep the
    // lower mode number (DC beats H beats V)
    always_comb begin
        winMode = MODE_DC;
        winSad  = sadDc_q;
        if (sadH_q < winSad) begin
            winMode = MODE_H;
            winSad  = sadH_q;
        end
        if (sadV_q < winSad) begin
            winMode = MODE_V;
            winSad  = sadV_q;
        end
    end

    // Prediction row of the chosen mode feeds the residual subtractor
    always_comb begin
        case (bestMode_q)
            MODE_H:  bestRow = hRow;
            MODE_V:  bestRow = vRow;
            default: bestRow = dcRow;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: ACCUM and EMIT both walk rows 0..7; EMIT only advances on a transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_ACCUM;
            ST_ACCUM:  if (row_q == LAST_ROW) state_d = ST_DECIDE;
            ST_DECIDE: state_d = ST_EMIT;
            ST_EMIT:   if (res_ready_i && row_q == LAST_ROW) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode; residual fields are forced to zero outside EMIT so they
    // never expose stale or uninitialised latched pixels
    always_comb begin
        busy_o       = (state_q != ST_IDLE);
        mode_valid_o = modeValid_q;
        best_mode_o  = bestMode_q;
        best_sad_o   = bestSad_q;
        res_valid_o  = (state_q == ST_EMIT);
        res_row_o    = (state_q == ST_EMIT) ? row_q : 3'd0;
        res_last_o   = (state_q == ST_EMIT) && (row_q == LAST_ROW);
        res_data_o   = '0;
        if (state_q == ST_EMIT) begin
            for (int c = 0; c < 8; c++) begin
                res_data_o[c] = {1'b0, origRow[c]} - {1'b0, bestRow[c]};
            end
        end
    end

    // Input capture happens only on an accepted start; pixel arrays need no
    // reset because nothing reads them before the first capture
    always_ff @(posedge clk) begin
        if (!reset && state_q == ST_IDLE && start_i) begin
            origPix_q <= origpixels_i;
            vPred_q   <= vpred_i;
            hPred_q   <= hpred_i;
            dcPred_q  <= dcpred_i;
        end
    end

    // Row counter, SAD accumulators and the decision registers
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q       <= 3'd0;
            sadDc_q     <= '0;
            sadH_q      <= '0;
            sadV_q      <= '0;
            bestMode_q  <= MODE_DC;
            bestSad_q   <= '0;
            modeValid_q <= 1'b0;
        end else begin
            modeValid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        row_q   <= 3'd0;
                        sadDc_q <= '0;
                        sadH_q  <= '0;
                        sadV_q  <= '0;
                    end
                end
                ST_ACCUM: begin
                    sadDc_q <= sadDc_q + SAD_W'(rowSadDc);
                    sadH_q  <= sadH_q  + SAD_W'(rowSadH);
                    sadV_q  <= sadV_q  + SAD_W'(rowSadV);
                    row_q   <= row_q + 3'd1;
                end
                ST_DECIDE: begin
                    bestMode_q  <= winMode;
                    bestSad_q   <= winSad;
                    modeValid_q <= 1'b1;
                    row_q       <= 3'd0;
                end
                ST_EMIT: begin
                    if (res_ready_i) begin
                        row_q <= row_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
